// File: rtl/cp2_issue_if_if.sv
// Bundle of the CPU-side request/response handshake and the CP2 transfer port.
// slave is the issue unit's view; master is the pipeline/coprocessor side.
interface cp2_issue_if_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_ir;
  logic [31:0] req_wdata;
  logic        flush;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_exc;
  logic [4:0]  rsp_exccode;

  logic        cp2_irenable_0;
  logic [31:0] cp2_ir_0;
  logic        cp2_ts_0;
  logic        cp2_fs_0;
  logic        cp2_as_0;
  logic        cp2_tds_0;
  logic [31:0] cp2_tdata_0;
  logic        cp2_fds_0;
  logic [31:0] cp2_fdata_0;
  logic        cp2_execs_0;
  logic        cp2_exc_0;
  logic [4:0]  cp2_exccode_0;

  modport slave (
    input  req_valid, req_ir, req_wdata, flush,
    input  cp2_fds_0, cp2_fdata_0, cp2_execs_0, cp2_exc_0, cp2_exccode_0,
    output req_ready, rsp_valid, rsp_rdata, rsp_exc, rsp_exccode,
    output cp2_irenable_0, cp2_ir_0, cp2_ts_0, cp2_fs_0, cp2_as_0,
    output cp2_tds_0, cp2_tdata_0
  );

  modport master (
    output req_valid, req_ir, req_wdata, flush,
    output cp2_fds_0, cp2_fdata_0, cp2_execs_0, cp2_exc_0, cp2_exccode_0,
    input  req_ready, rsp_valid, rsp_rdata, rsp_exc, rsp_exccode,
    input  cp2_irenable_0, cp2_ir_0, cp2_ts_0, cp2_fs_0, cp2_as_0,
    input  cp2_tds_0, cp2_tdata_0
  );
endinterface

// File: rtl/cp2_issue_if.sv
// Issues one CP2 instruction at a time: strobe the word, do the transfer,
// wait for completion/exception/timeout, then return a one-cycle response.
//
// state   | meaning
// IDLE    | ready for a request
// ISSUE   | instruction word strobed to CP2
// XFER    | fs/ts/as transfer select (plus write data for MTC2)
// WAIT    | waiting for fds/execs/exc or timeout
// DONE    | response pulse to the pipeline
module cp2_issue_if #(
  parameter int unsigned TIMEOUT    = 15,
  parameter logic [4:0]  TO_EXCCODE = 5'h1F
) (
  input logic         clk,
  input logic         rst_n,
  cp2_issue_if_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_XFER  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_MFC2 = 2'd0,
    OP_MTC2 = 2'd1,
    OP_ACT  = 2'd2
  } op_t;

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exc_q, exc_d;
  logic [4:0]  exccode_q, exccode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ACT;
      ir_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      exc_q     <= 1'b0;
      exccode_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ir_q      <= ir_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      exc_q     <= exc_d;
      exccode_q <= exccode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ir_d      = ir_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    exc_d     = exc_q;
    exccode_d = exccode_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          ir_d    = bus.req_ir;
          wdata_d = bus.req_wdata;
          if (bus.req_ir[25:21] == 5'b00000)      op_d = OP_MFC2;
          else if (bus.req_ir[25:21] == 5'b00100) op_d = OP_MTC2;
          else                                    op_d = OP_ACT;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_XFER;
      S_XFER: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // exception beats data/done; a real completion beats the timeout
        if (bus.cp2_exc_0) begin
          rdata_d   = '0;
          exc_d     = 1'b1;
          exccode_d = bus.cp2_exccode_0;
          state_d   = S_DONE;
        end else if (op_q == OP_MFC2 && bus.cp2_fds_0) begin
          rdata_d   = bus.cp2_fdata_0;
          exc_d     = 1'b0;
          exccode_d = '0;
          state_d   = S_DONE;
        end else if (op_q != OP_MFC2 && bus.cp2_execs_0) begin
          rdata_d   = '0;
          exc_d     = 1'b0;
          exccode_d = '0;
          state_d   = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          rdata_d   = '0;
          exc_d     = 1'b1;
          exccode_d = TO_EXCCODE;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.cp2_irenable_0 = (state_q == S_ISSUE);
  assign bus.cp2_ir_0       = (state_q == S_ISSUE) ? ir_q : '0;
  assign bus.cp2_fs_0       = (state_q == S_XFER) && (op_q == OP_MFC2);
  assign bus.cp2_ts_0       = (state_q == S_XFER) && (op_q == OP_MTC2);
  assign bus.cp2_as_0       = (state_q == S_XFER) && (op_q == OP_ACT);
  assign bus.cp2_tds_0      = (state_q == S_XFER) && (op_q == OP_MTC2);
  assign bus.cp2_tdata_0    = ((state_q == S_XFER) && (op_q == OP_MTC2)) ? wdata_q : '0;
  assign bus.rsp_valid      = (state_q == S_DONE);
  assign bus.rsp_rdata      = (state_q == S_DONE) ? rdata_q : '0;
  assign bus.rsp_exc        = (state_q == S_DONE) && exc_q;
  assign bus.rsp_exccode    = (state_q == S_DONE) ? exccode_q : '0;

endmodule

// File: tb/tb_cp2_issue_if.sv
// Bench for cp2_issue_if: a per-cycle expected-output timeline built from each
// transaction's CP2 response plan, compared every cycle, plus literal checks.
module tb_cp2_issue_if;
  localparam int TO = 15;
  localparam int NCYC = 1024;

  typedef struct packed {
    logic        ready;
    logic        irenable;
    logic [31:0] ir;
    logic        ts;
    logic        fs;
    logic        as_s;
    logic        tds;
    logic [31:0] tdata;
    logic        rv;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q [NCYC];
  exp_t idle_e;

  int          obs_cyc = -1;
  int          obs_cnt = 0;
  logic [31:0] obs_rdata;
  logic        obs_exc;
  logic [4:0]  obs_code;

  cp2_issue_if_if bus ();

  cp2_issue_if #(.TIMEOUT(TO), .TO_EXCCODE(5'h1F)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle compare against the planned timeline
  always @(negedge clk) begin
    exp_t act;
    act.ready    = bus.req_ready;
    act.irenable = bus.cp2_irenable_0;
    act.ir       = bus.cp2_ir_0;
    act.ts       = bus.cp2_ts_0;
    act.fs       = bus.cp2_fs_0;
    act.as_s     = bus.cp2_as_0;
    act.tds      = bus.cp2_tds_0;
    act.tdata    = bus.cp2_tdata_0;
    act.rv       = bus.rsp_valid;
    act.rdata    = bus.rsp_rdata;
    act.exc      = bus.rsp_exc;
    act.code     = bus.rsp_exccode;
    if (cyc < NCYC) begin
      tests = tests + 1;
      if (act !== exp_q[cyc]) begin
        fails = fails + 1;
        $display("FAIL outputs cyc%0d got %h required %h", cyc, act, exp_q[cyc]);
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      obs_cyc   = cyc;
      obs_cnt   = obs_cnt + 1;
      obs_rdata = bus.rsp_rdata;
      obs_exc   = bus.rsp_exc;
      obs_code  = bus.rsp_exccode;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests = tests + 1;
    if (got !== req) begin
      fails = fails + 1;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // kind: 0 none, 1 fds, 2 execs, 3 exc, 4 fds+exc; strobe on WAIT cycle d
  task automatic plan(input logic [31:0] ir, input logic [31:0] wdata, input int kind,
                      input int d, input logic [31:0] fdata, input logic [4:0] code,
                      input int abort_off, input int c, output int last);
    logic [4:0] fmt;
    bit   is_mfc, is_mtc, exc_resp, comp;
    int   k;
    exp_t e;
    fmt      = ir[25:21];
    is_mfc   = (fmt == 5'b00000);
    is_mtc   = (fmt == 5'b00100);
    exc_resp = (kind == 3 || kind == 4);
    comp     = (d >= 1) && (d <= TO) &&
               (exc_resp || (is_mfc && kind == 1) || (!is_mfc && kind == 2));
    k = comp ? d : TO;
    e = idle_e; e.ready = 1'b0; e.irenable = 1'b1; e.ir = ir;
    exp_q[c+1] = e;
    e = idle_e; e.ready = 1'b0;
    e.fs = is_mfc; e.ts = is_mtc; e.as_s = !is_mfc && !is_mtc;
    e.tds = is_mtc; e.tdata = is_mtc ? wdata : 32'h0;
    exp_q[c+2] = e;
    for (int j = 1; j <= k; j++) begin
      e = idle_e; e.ready = 1'b0;
      exp_q[c+2+j] = e;
    end
    e = idle_e; e.ready = 1'b0; e.rv = 1'b1;
    e.rdata = (comp && is_mfc && !exc_resp) ? fdata : 32'h0;
    e.exc   = !comp || exc_resp;
    e.code  = !comp ? 5'h1F : (exc_resp ? code : 5'h00);
    exp_q[c+3+k] = e;
    last = c + 3 + k;
    if (abort_off > 0) begin
      for (int n = c + abort_off + 1; n <= c + 3 + k; n++) exp_q[n] = idle_e;
      last = c + abort_off;
    end
    if (kind != 0 && c + 2 + d > last) last = c + 2 + d;
  endtask

  // called at a negedge; returns at the negedge of the first cycle after the plan
  task automatic run_txn(input logic [31:0] ir, input logic [31:0] wdata, input int kind,
                         input int d, input logic [31:0] fdata, input logic [4:0] code,
                         input int abort_off, input bit noise, output int c_acc);
    int  c, last;
    bit  strobe, nz;
    c = cyc;
    c_acc = c;
    plan(ir, wdata, kind, d, fdata, code, abort_off, c, last);
    bus.req_valid     = 1'b1;
    bus.req_ir        = ir;
    bus.req_wdata     = wdata;
    bus.cp2_fdata_0   = fdata;
    bus.cp2_exccode_0 = code;
    for (int n = c + 1; n <= last; n++) begin
      @(negedge clk);
      strobe = (kind != 0) && (n == c + 2 + d);
      nz     = noise && (n <= c + 2);
      bus.req_valid   = 1'b0;
      bus.flush       = (abort_off > 0) && (n == c + abort_off);
      bus.cp2_fds_0   = (strobe && (kind == 1 || kind == 4)) || nz;
      bus.cp2_execs_0 = (strobe && kind == 2) || nz;
      bus.cp2_exc_0   = (strobe && (kind == 3 || kind == 4)) || nz;
    end
    @(negedge clk);
    bus.req_valid   = 1'b0;
    bus.flush       = 1'b0;
    bus.cp2_fds_0   = 1'b0;
    bus.cp2_execs_0 = 1'b0;
    bus.cp2_exc_0   = 1'b0;
  endtask

  initial begin
    int c, c2, last, r1, cnt0;
    idle_e = '0;
    idle_e.ready = 1'b1;
    for (int i = 0; i < NCYC; i++) exp_q[i] = idle_e;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_ir = '0; bus.req_wdata = '0; bus.flush = 1'b0;
    bus.cp2_fds_0 = 1'b0; bus.cp2_fdata_0 = '0; bus.cp2_execs_0 = 1'b0;
    bus.cp2_exc_0 = 1'b0; bus.cp2_exccode_0 = '0;

    @(negedge clk);
    check("reset_ready", {31'h0, bus.req_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("reset_irenable", {31'h0, bus.cp2_irenable_0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MFC2, fds on first WAIT cycle, with stray strobes during ISSUE/XFER
    run_txn(32'h4800_0009, 32'h0, 1, 1, 32'h1234_5678, 5'h00, 0, 1'b1, c);
    check("mfc2_latency", obs_cyc - c, 32'd4);
    check("mfc2_rdata", obs_rdata, 32'h1234_5678);
    check("mfc2_exc", {31'h0, obs_exc}, 32'h0);

    // MTC2, execs after 3 WAIT cycles
    run_txn(32'h4880_0011, 32'hDEAD_BEEF, 2, 3, 32'h5555_AAAA, 5'h00, 0, 1'b0, c);
    check("mtc2_latency", obs_cyc - c, 32'd6);
    check("mtc2_rdata", obs_rdata, 32'h0);

    // ACTION, no response -> timeout after 15 WAIT cycles
    run_txn(32'h4A00_0000, 32'h0, 0, 0, 32'h0, 5'h00, 0, 1'b0, c);
    check("timeout_latency", obs_cyc - c, 32'd18);
    check("timeout_exc", {31'h0, obs_exc}, 32'h1);
    check("timeout_code", {27'h0, obs_code}, 32'h1F);

    // MFC2 fds and exc in the same cycle
    run_txn(32'h4800_0009, 32'h0, 4, 2, 32'hCAFE_F00D, 5'h03, 0, 1'b0, c);
    check("exc_prio_code", {27'h0, obs_code}, 32'h03);
    check("exc_prio_rdata", obs_rdata, 32'h0);

    // flush during WAIT, then a late fds
    cnt0 = obs_cnt;
    run_txn(32'h4800_0001, 32'h0, 1, 4, 32'h1111_2222, 5'h00, 4, 1'b0, c);
    check("flush_no_rsp", obs_cnt - cnt0, 32'd0);

    // flush in ISSUE and in XFER
    run_txn(32'h4880_0002, 32'h7777_8888, 2, 2, 32'h0, 5'h00, 1, 1'b0, c);
    run_txn(32'h4A20_0003, 32'h0, 2, 1, 32'h0, 5'h00, 2, 1'b0, c);
    check("flush_issue_xfer_no_rsp", obs_cnt - cnt0, 32'd0);

    // completion on the timeout cycle wins; one cycle later loses
    run_txn(32'h4880_0004, 32'h0102_0304, 2, 15, 32'h0, 5'h00, 0, 1'b0, c);
    check("late_win_exc", {31'h0, obs_exc}, 32'h0);
    run_txn(32'h4A00_0005, 32'h0, 2, 16, 32'h0, 5'h00, 0, 1'b0, c);
    check("late_lose_code", {27'h0, obs_code}, 32'h1F);

    // MFC2 answered only with execs: ignored, times out
    run_txn(32'h4800_0006, 32'h0, 2, 2, 32'h9999_9999, 5'h00, 0, 1'b0, c);
    check("mfc2_execs_latency", obs_cyc - c, 32'd18);

    // ACTION with CP2 exception
    run_txn(32'h4BE0_0007, 32'h0, 3, 5, 32'h0, 5'h0A, 0, 1'b0, c);
    check("action_exc_code", {27'h0, obs_code}, 32'h0A);

    // flush in IDLE blocks acceptance
    bus.req_valid = 1'b1; bus.req_ir = 32'h4800_0008; bus.flush = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    check("idle_flush_ready", {31'h0, bus.req_ready}, 32'h1);

    // reset during XFER
    cnt0 = obs_cnt;
    c = cyc;
    plan(32'h4880_0010, 32'hABCD_0123, 0, 0, 32'h0, 5'h00, 2, c, last);
    bus.req_valid = 1'b1; bus.req_ir = 32'h4880_0010; bus.req_wdata = 32'hABCD_0123;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_xfer_ts", {31'h0, bus.cp2_ts_0}, 32'h0);
    check("rst_xfer_tds", {31'h0, bus.cp2_tds_0}, 32'h0);
    check("rst_xfer_tdata", bus.cp2_tdata_0, 32'h0);
    check("rst_xfer_ready", {31'h0, bus.req_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_rsp", obs_cnt - cnt0, 32'd0);

    // back-to-back MFC2s after reset
    run_txn(32'h4800_000A, 32'h0, 1, 1, 32'h0BAD_F00D, 5'h00, 0, 1'b0, c);
    r1 = obs_cyc;
    check("after_rst_rdata", obs_rdata, 32'h0BAD_F00D);
    run_txn(32'h4800_000B, 32'h0, 1, 1, 32'h600D_CAFE, 5'h00, 0, 1'b0, c2);
    check("b2b_spacing", obs_cyc - r1, 32'd5);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
